// File: rtl/main_memory_pkg.sv
// Shared constants and sizing helper for the main memory block.
package main_memory_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 8;
  localparam int DEFAULT_DATA_WIDTH = 8;

  // Number of words addressed by an address bus of the given width.
  function automatic int mem_depth(input int addr_width);
    logic [31:0] depth_s;
    depth_s = 32'd1 << addr_width;
    return int'(depth_s);
  endfunction

  localparam int MEM_DEPTH = mem_depth(DEFAULT_ADDR_WIDTH);

endpackage

// File: rtl/main_memory.sv
// Single-clock RAM: synchronous write port, combinational read port,
// whole array cleared by an asynchronous active-high reset.
module main_memory
  import main_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write,
  input  logic                  clock,
  output logic [DATA_WIDTH-1:0] read_out,
  input  logic                  reset
);

  localparam int DEPTH = mem_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // Storage array: reset clears every word and overrides a same-edge write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (write) begin
      mem_r[write_addr] <= write_data;
    end
  end

  // No write_data bypass: a same-address write shows up only after the edge.
  assign read_out = mem_r[read_addr];

endmodule

// File: tb/tb_main_memory.sv
// Self-checking bench for main_memory: directed vector table, hand-written
// reset sequences, and randomized traffic against an array reference model.
module tb_main_memory;

  logic [7:0] read_addr;
  logic [7:0] write_addr;
  logic [7:0] write_data;
  logic       write;
  logic       clock;
  logic       reset;
  logic [7:0] read_out;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] ref_mem [256];

  main_memory #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .read_addr  (read_addr),
    .write_addr (write_addr),
    .write_data (write_data),
    .write      (write),
    .clock      (clock),
    .read_out   (read_out),
    .reset      (reset)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       wr;
    logic [7:0] waddr;
    logic [7:0] wdata;
    logic [7:0] raddr;
    logic [7:0] exp_pre;
    logic [7:0] exp_post;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: read_out=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
  endtask

  initial begin
    reset      = 1'b0;
    write      = 1'b0;
    write_addr = 8'd0;
    write_data = 8'd0;
    read_addr  = 8'd0;

    //                wr    waddr   wdata  raddr   pre    post
    vecs[0]  = '{1'b1, 8'd10,  8'h55, 8'd10,  8'h00, 8'h55};
    vecs[1]  = '{1'b1, 8'd11,  8'h05, 8'd11,  8'h00, 8'h05};
    vecs[2]  = '{1'b1, 8'd15,  8'hFF, 8'd11,  8'h05, 8'h05};
    vecs[3]  = '{1'b0, 8'd0,   8'h00, 8'd15,  8'hFF, 8'hFF};
    vecs[4]  = '{1'b0, 8'd11,  8'hAA, 8'd11,  8'h05, 8'h05};
    vecs[5]  = '{1'b0, 8'd11,  8'hAA, 8'd11,  8'h05, 8'h05};
    vecs[6]  = '{1'b0, 8'd11,  8'hAA, 8'd11,  8'h05, 8'h05};
    vecs[7]  = '{1'b1, 8'd20,  8'h12, 8'd20,  8'h00, 8'h12};
    vecs[8]  = '{1'b1, 8'd20,  8'h34, 8'd20,  8'h12, 8'h34};
    vecs[9]  = '{1'b1, 8'd0,   8'h01, 8'd255, 8'h00, 8'h00};
    vecs[10] = '{1'b1, 8'd255, 8'h80, 8'd0,   8'h01, 8'h01};
    vecs[11] = '{1'b0, 8'd0,   8'h00, 8'd255, 8'h80, 8'h80};

    // Reset from power-up; array contents are undefined until then.
    #2 reset = 1'b1;
    #1;
    for (int a = 0; a < 256; a += 51) begin
      read_addr = 8'(a);
      #1 check("reset_state", read_out, 8'h00);
    end
    @(negedge clock);
    reset = 1'b0;

    // Directed vector table: check before and after each rising edge.
    for (int v = 0; v < 12; v++) begin
      @(negedge clock);
      write      = vecs[v].wr;
      write_addr = vecs[v].waddr;
      write_data = vecs[v].wdata;
      read_addr  = vecs[v].raddr;
      #1 check($sformatf("vec%0d_pre", v), read_out, vecs[v].exp_pre);
      @(posedge clock);
      #1 check($sformatf("vec%0d_post", v), read_out, vecs[v].exp_post);
    end
    @(negedge clock);
    write = 1'b0;
    read_addr = 8'd0;
    #1 check("boundary_addr0", read_out, 8'h01);

    // Async reset between edges clears the array immediately.
    #1 reset = 1'b1;
    #1 read_addr = 8'd10;
    #1 check("async_reset_a10", read_out, 8'h00);
    read_addr = 8'd11;
    #1 check("async_reset_a11", read_out, 8'h00);
    read_addr = 8'd15;
    #1 check("async_reset_a15", read_out, 8'h00);

    // Write attempted while reset is held is ignored.
    @(negedge clock);
    write = 1'b1; write_addr = 8'd11; write_data = 8'hAA; read_addr = 8'd11;
    @(posedge clock);
    #1 check("write_during_reset", read_out, 8'h00);

    // Release reset between edges; the very next edge commits a write.
    @(negedge clock);
    reset = 1'b0;
    write_data = 8'h3C;
    #1 check("post_reset_pre", read_out, 8'h00);
    @(posedge clock);
    #1 check("post_reset_first_write", read_out, 8'h3C);

    // Changes between edges are not sampled.
    @(negedge clock);
    write = 1'b1; write_addr = 8'd11; write_data = 8'h77;
    #2 write = 1'b0;
    @(posedge clock);
    #1 check("between_edge_write_ignored", read_out, 8'h3C);

    // Randomized traffic against the array model.
    model_clear();
    @(negedge clock);
    reset = 1'b1;
    #1 reset = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      write      = ($urandom_range(0, 3) != 0);
      write_addr = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
      write_data = 8'($urandom_range(0, 255));
      read_addr  = ($urandom_range(0, 2) == 0) ? write_addr : 8'($urandom_range(0, 7));
      #1 check("rand_pre", read_out, ref_mem[read_addr]);
      @(posedge clock);
      if (write) ref_mem[write_addr] = write_data;
      #1 check("rand_post", read_out, ref_mem[read_addr]);
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b1;
        model_clear();
        #1 check("rand_reset", read_out, ref_mem[read_addr]);
        #1 reset = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
